// File: rtl/datapath_pkg.sv
// Shared integer data-path constants and the write-select validity check,
// used by the register file and the decoder-facing control stage.
package datapath_pkg;

   localparam int DATA_W     = 16;
   localparam int NUM_REGS   = 8;
   localparam int REG_ADDR_W = 3;

   // True only when exactly one write-select bit is high.
   function automatic logic isOneHot(input logic [NUM_REGS-1:0] sel);
      return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/reg_file_onehot_if.sv
// Write/read bus between the decoder-side control stage (master)
// and the eight-entry register file (slave).
interface reg_file_onehot_if;
   import datapath_pkg::*;

   logic [NUM_REGS-1:0]   we_onehot;
   logic [DATA_W-1:0]     wd;
   logic [REG_ADDR_W-1:0] ra;
   logic [REG_ADDR_W-1:0] rb;
   logic [DATA_W-1:0]     rd_a;
   logic [DATA_W-1:0]     rd_b;
   logic                  wr_done;
   logic                  sel_err;

   modport master (
      output we_onehot, wd, ra, rb,
      input  rd_a, rd_b, wr_done, sel_err
   );

   modport slave (
      input  we_onehot, wd, ra, rb,
      output rd_a, rd_b, wr_done, sel_err
   );

endinterface

// File: rtl/reg16_ld.sv
// Single data-path register with synchronous active-high reset and load enable.
module reg16_ld #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_file_onehot.sv
// Eight-entry register file fed by one-hot write enables, with two registered
// read ports, same-cycle write bypass, and sticky rejection of multi-hot selects.
module reg_file_onehot #(
   parameter int DATA_W   = datapath_pkg::DATA_W,
   parameter int NUM_REGS = datapath_pkg::NUM_REGS
) (
   input  logic             clk,
   input  logic             reset,
   reg_file_onehot_if.slave bus
);

   logic                w_writeOk;
   logic                w_multiHot;
   logic [DATA_W-1:0]   w_regs [NUM_REGS];
   logic                w_bypassA;
   logic                w_bypassB;

   logic [DATA_W-1:0]   r_rdA;
   logic [DATA_W-1:0]   r_rdB;
   logic                r_wrDone;
   logic                r_selErr;

   assign w_writeOk  = datapath_pkg::isOneHot(bus.we_onehot);
   assign w_multiHot = (bus.we_onehot != '0) && !w_writeOk;

   // Load is gated by the validity check so a faulty select writes nothing.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      reg16_ld #(.WIDTH(DATA_W)) u_reg (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_writeOk & bus.we_onehot[i]),
         .i_d    (bus.wd),
         .o_q    (w_regs[i])
      );
   end

   assign w_bypassA = w_writeOk & bus.we_onehot[bus.ra];
   assign w_bypassB = w_writeOk & bus.we_onehot[bus.rb];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdA    <= '0;
         r_rdB    <= '0;
         r_wrDone <= 1'b0;
         r_selErr <= 1'b0;
      end else begin
         r_rdA    <= w_bypassA ? bus.wd : w_regs[bus.ra];
         r_rdB    <= w_bypassB ? bus.wd : w_regs[bus.rb];
         r_wrDone <= w_writeOk;
         r_selErr <= r_selErr | w_multiHot;
      end
   end

   assign bus.rd_a    = r_rdA;
   assign bus.rd_b    = r_rdB;
   assign bus.wr_done = r_wrDone;
   assign bus.sel_err = r_selErr;

endmodule
